cga_pixel_shifter: RTL
======================

// Module: cga_pixel_shifter
// PURPOSE
//  Video serializer ahead of the composite encoder. Turns fetched VRAM bytes into a 4-bit IRGB pixel stream,
//  with delayed hsync/vsync_l aligned to that stream. Handles text, 320x200 4-colour and 640x200 2-colour.
//  Resolves blink, cursor, border and palette. Upstream sequencer supplies pix_ce/char_load strobes per mode.
// PARAMETERS
//  CURSOR_BIT  3  frame-counter bit giving cursor phase (toggles every 8 frames)
//  BLINK_BIT   4  frame-counter bit giving attribute-blink phase (toggles every 16 frames)
// PORTS
//  clk           in   1   28.636 MHz system clock
//  reset_n       in   1   asynchronous, active-low reset
//  pix_ce        in   1   one-clk strobe per output pixel; pulses are >=2 clk apart
//  char_load     in   1   group start; only asserted together with pix_ce
//  byte0         in   8   text: character code; gfx: first graphics byte
//  byte1         in   8   text: attribute; gfx: second graphics byte
//  row_addr      in   3   character scanline
//  cursor        in   1   group lies under the CRTC cursor
//  display_en    in   1   active display area
//  hsync_in      in   1   horizontal sync from CRTC
//  vsync_l_in    in   1   vertical sync from CRTC, active-low
//  graphics      in   1   mode: 1 = graphics
//  hires_gfx     in   1   mode: 1 = 640-wide graphics
//  bw_mode       in   1   mode: selects fixed 320 palette
//  blink_en      in   1   mode: attr[7] means blink, not bright background
//  colour_sel    in   6   colour-select register value
//  font_addr     out  11  {byte0, row_addr} to font ROM
//  font_data     in   8   ROM data, valid 1 clk after font_addr
//  video         out  4   IRGB pixel
//  hsync_out     out  1   delayed hsync
//  vsync_l_out   out  1   delayed vsync_l
// BEHAVIOUR
//  Reset values: video=0, hsync_out=0, vsync_l_out=1, font_addr=0; shifter, frame counter and pipelines clear.
//  Stage A (clk with char_load): capture byte0/1, cursor, display_en, syncs and all mode inputs.
//   font_addr is registered in the same clk.
//  Font capture: 1 clk later, font_data is latched into stage A (text mode only; ignored in graphics).
//  Stage B (next char_load): A -> shift register, pixel index := 0. Latency is exactly one group.
//  Mode inputs affect only groups loaded after a change. Nothing changes mid-group.
//  video is a register updated only on pix_ce. With char_load: pixel 0 of new group B. Otherwise: next pixel.
//  Group length: text 8 px (font byte, MSB first); 320 mode 8 px (2 bits each, byte0[7:6] first, then byte1).
//   640 mode: 16 px (byte0[7] .. byte1[0]).
//  Exhausted group with no char_load: zeros shift in (index 0 colour). Early char_load truncates the old group.
//  Text colour: bit=1 -> fg attr[3:0]. bit=0 -> bg {blink_en?0:attr[7], attr[6:4]}.
//   If blink_en & attr[7] & blink_phase: fg is replaced by bg.
//   If cursor & cursor_phase: all 8 px are fg.
//  320 colour: idx 0 -> colour_sel[3:0]. idx 1..3 -> {colour_sel[4], rgb}.
//   rgb = 3,5,7 when colour_sel[5]; 2,4,6 otherwise; 3,4,7 when bw_mode.
//  640 colour: bit=1 -> colour_sel[3:0], bit=0 -> 0.
//  Border (delayed display_en=0): colour_sel[3:0]; 0 in 640 mode.
//   Delayed hsync=1 or delayed vsync_l=0: video forced to 0.
//  hsync_out/vsync_l_out: the stage-B copies, so they change on the char_load clk that starts the group.
//  Frame counter: 5-bit, increments on each 1->0 edge of vsync_l_in (2-flop edge detect), wraps 31->0.
//   cursor_phase = cnt[CURSOR_BIT], blink_phase = cnt[BLINK_BIT].
//  Async reset mid-line: all state clears immediately. First group after release outputs border/0 until B loads.
// STRUCTURE
//  cga_pkg: mode encodings, 320 palette tables, group-length constants (8/16).
//  Sub-module cga_palette_mux: combinational pixel bits + attr/mode/phases -> IRGB.
//  Pipelines, shifter and frame counter stay in this module.
// TESTING
//  Reset: hold reset_n=0 with random inputs -> video=0, vsync_l_out=1, font_addr=0. Holds until first pix_ce.
//  Text: byte0=0x41, byte1=0x1E, row 3 -> font_addr=0x20B.
//   With font_data=0x18, next group gives 1,1,1,E,E,1,1,1.
//  Blink: attr 0x9E, blink_en=1, after 16 vsync_l falls -> 8 px of 1.
//   With blink_en=0 instead -> 9,9,9,E,E,9,9,9.
//  320: colour_sel=0x31, byte0=0x1B, byte1=0x00 -> 1,B,D,F,1,1,1,1. With bw_mode=1 -> 1,B,C,F,1,1,1,1.
//  640: colour_sel=0x0C, bytes 0xA5,0x0F -> C,0,C,0,0,C,0,C,0,0,0,0,C,C,C,C.
//  Sync/border: display_en=0 in group N -> group N+1 px = colour_sel[3:0].
//   hsync_in=1 in group N -> hsync_out=1 from the group N+1 char_load, and video=0.

Source files
------------

// File: rtl/cga_pkg.sv
// Shared types and constants for the CGA pixel shifter.
//   mode_e      : pixel-group format (text, 320 4-colour, 640 2-colour)
//   cfg_t       : per-group colour/sync/mode state carried through the pipeline
//   grp_t       : full stage-A capture (raw bytes, font byte, cfg)
//   pal320_rgb  : fixed RGB tables of the 320-wide mode
package cga_pkg;

  typedef enum logic [1:0] {
    ModeText = 2'd0,
    Mode320  = 2'd1,
    Mode640  = 2'd2
  } mode_e;

  // Pixel index counter width; must hold the longest group length.
  localparam int unsigned IdxW = 5;
  localparam logic [IdxW-1:0] GroupLenNarrow = 5'd8;
  localparam logic [IdxW-1:0] GroupLenWide   = 5'd16;

  // 320-mode RGB for pixel indices 3,2,1 (packed MSB first).
  localparam logic [8:0] Pal320Cyan  = {3'd7, 3'd5, 3'd3};
  localparam logic [8:0] Pal320Green = {3'd6, 3'd4, 3'd2};
  localparam logic [8:0] Pal320Bw    = {3'd7, 3'd4, 3'd3};

  typedef struct packed {
    logic       cursor;
    logic       display_en;
    logic       hsync;
    logic       vsync_l;
    mode_e      mode;
    logic       bw_mode;
    logic       blink_en;
    logic [5:0] colour_sel;
    logic       cursor_phase;
    logic       blink_phase;
  } cfg_t;

  typedef struct packed {
    logic [7:0] byte0;
    logic [7:0] byte1;
    logic [7:0] font;
    cfg_t       cfg;
  } grp_t;

  function automatic mode_e mode_decode(input logic graphics, input logic hires_gfx);
    mode_e m;
    if (!graphics)      m = ModeText;
    else if (hires_gfx) m = Mode640;
    else                m = Mode320;
    return m;
  endfunction

  function automatic logic [IdxW-1:0] group_len(input mode_e m);
    return (m == Mode640) ? GroupLenWide : GroupLenNarrow;
  endfunction

  // Idle state: no sync asserted (vsync is active-low), border everywhere else.
  function automatic cfg_t cfg_reset();
    cfg_t c;
    c         = '0;
    c.vsync_l = 1'b1;
    return c;
  endfunction

  function automatic grp_t grp_reset();
    grp_t g;
    g     = '0;
    g.cfg = cfg_reset();
    return g;
  endfunction

  function automatic logic [2:0] pal320_rgb(input logic [1:0] idx, input logic cs5,
                                            input logic bw);
    logic [8:0] tbl;
    logic [2:0] rgb;
    if (bw)       tbl = Pal320Bw;
    else if (cs5) tbl = Pal320Cyan;
    else          tbl = Pal320Green;
    case (idx)
      2'd1:    rgb = tbl[2:0];
      2'd2:    rgb = tbl[5:3];
      2'd3:    rgb = tbl[8:6];
      default: rgb = 3'd0;
    endcase
    return rgb;
  endfunction

endpackage

// File: rtl/cga_pixel_shifter_if.sv
// Fetch/video bundle between the CGA sequencer and the pixel shifter.
//   pix_ce, char_load         : pixel and group-start strobes
//   byte0, byte1, row_addr    : fetched VRAM bytes and character scanline
//   cursor, display_en        : per-group CRTC qualifiers
//   hsync_in, vsync_l_in      : raw CRTC syncs
//   video, hsync_out, vsync_l_out : serialized IRGB and aligned syncs
// master = sequencer side, slave = shifter side.
interface cga_pixel_shifter_if;
  logic       pix_ce;
  logic       char_load;
  logic [7:0] byte0;
  logic [7:0] byte1;
  logic [2:0] row_addr;
  logic       cursor;
  logic       display_en;
  logic       hsync_in;
  logic       vsync_l_in;
  logic [3:0] video;
  logic       hsync_out;
  logic       vsync_l_out;

  modport master (
    output pix_ce, char_load, byte0, byte1, row_addr, cursor, display_en, hsync_in,
           vsync_l_in,
    input  video, hsync_out, vsync_l_out
  );

  modport slave (
    input  pix_ce, char_load, byte0, byte1, row_addr, cursor, display_en, hsync_in,
           vsync_l_in,
    output video, hsync_out, vsync_l_out
  );
endinterface

// File: rtl/cga_palette_mux.sv
// Combinational colour resolution for one pixel.
//   cfg      : group mode/colour/sync state
//   attr     : text attribute byte (unused in graphics modes)
//   pix      : pixel bits from the top of the shifter; pix[1] is the 1bpp bit
//   in_group : pixel still lies inside the group (limits cursor forcing)
//   colour   : IRGB result
module cga_palette_mux
  import cga_pkg::*;
(
  input  cfg_t       cfg,
  input  logic [7:0] attr,
  input  logic [1:0] pix,
  input  logic       in_group,
  output logic [3:0] colour
);

  logic [3:0] fg;
  logic [3:0] bg;
  logic       text_on;

  always_comb begin
    // With blink enabled, attr[7] is the blink flag, not background intensity.
    bg = {(cfg.blink_en ? 1'b0 : attr[7]), attr[6:4]};
    fg = attr[3:0];
    if (cfg.blink_en && attr[7] && cfg.blink_phase) fg = bg;
    text_on = pix[1] | (cfg.cursor & cfg.cursor_phase & in_group);

    colour = 4'd0;
    unique case (cfg.mode)
      ModeText: colour = text_on ? fg : bg;
      Mode320:  colour = (pix == 2'd0) ? cfg.colour_sel[3:0]
                         : {cfg.colour_sel[4], pal320_rgb(pix, cfg.colour_sel[5], cfg.bw_mode)};
      Mode640:  colour = pix[1] ? cfg.colour_sel[3:0] : 4'd0;
      default:  colour = 4'd0;
    endcase

    if (!cfg.display_en) colour = (cfg.mode == Mode640) ? 4'd0 : cfg.colour_sel[3:0];
    // Blanking during sync has the final say.
    if (cfg.hsync || !cfg.vsync_l) colour = 4'd0;
  end

endmodule

// File: rtl/cga_pixel_shifter.sv
// CGA pixel serializer: VRAM bytes -> 4-bit IRGB stream with aligned syncs.
//   clk, reset_n   : clock, asynchronous active-low reset
//   vid            : fetch/video bundle (slave side)
//   graphics, hires_gfx, bw_mode, blink_en, colour_sel : mode registers
//   font_addr      : {char, row} to font ROM, registered on group start
//   font_data      : font ROM byte, valid one clk after font_addr
// Two-stage pipeline: stage A captures a group on char_load, stage B (shifter)
// takes it on the following char_load, so output lags input by one group.
module cga_pixel_shifter
  import cga_pkg::*;
#(
  parameter int unsigned CURSOR_BIT = 3,
  parameter int unsigned BLINK_BIT  = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  cga_pixel_shifter_if.slave  vid,
  input  logic                graphics,
  input  logic                hires_gfx,
  input  logic                bw_mode,
  input  logic                blink_en,
  input  logic [5:0]          colour_sel,
  output logic [10:0]         font_addr,
  input  logic [7:0]          font_data
);

  logic            load;
  cfg_t            cfg_in;
  grp_t            grp_a_q;
  logic            font_pend_q;
  cfg_t            cfg_b_q, cfg_b_d;
  logic [7:0]      attr_b_q, attr_b_d;
  logic [15:0]     shift_q, shift_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic            in_group;
  logic [3:0]      colour_d;
  logic [3:0]      video_q;
  logic [1:0]      vs_sync_q;
  logic            vs_fall;
  logic [4:0]      frame_cnt_q;

  assign load = vid.pix_ce & vid.char_load;

  // Snapshot of everything that must stay constant for the whole group.
  always_comb begin
    cfg_in              = cfg_reset();
    cfg_in.cursor       = vid.cursor;
    cfg_in.display_en   = vid.display_en;
    cfg_in.hsync        = vid.hsync_in;
    cfg_in.vsync_l      = vid.vsync_l_in;
    cfg_in.mode         = mode_decode(graphics, hires_gfx);
    cfg_in.bw_mode      = bw_mode;
    cfg_in.blink_en     = blink_en;
    cfg_in.colour_sel   = colour_sel;
    cfg_in.cursor_phase = frame_cnt_q[CURSOR_BIT];
    cfg_in.blink_phase  = frame_cnt_q[BLINK_BIT];
  end

  // Stage A: capture on group start, then pick up the font byte one clk later.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      grp_a_q     <= grp_reset();
      font_pend_q <= 1'b0;
      font_addr   <= '0;
    end else begin
      font_pend_q <= load;
      if (load) begin
        grp_a_q.byte0 <= vid.byte0;
        grp_a_q.byte1 <= vid.byte1;
        grp_a_q.font  <= 8'h00;
        grp_a_q.cfg   <= cfg_in;
        font_addr     <= {vid.byte0, vid.row_addr};
      end else if (font_pend_q && (grp_a_q.cfg.mode == ModeText)) begin
        grp_a_q.font <= font_data;
      end
    end
  end

  // Frame counter on falling vsync_l, through a two-flop synchronizer/edge detect.
  assign vs_fall = vs_sync_q[1] & ~vs_sync_q[0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vs_sync_q   <= 2'b11;
      frame_cnt_q <= '0;
    end else begin
      vs_sync_q <= {vs_sync_q[0], vid.vsync_l_in};
      if (vs_fall) frame_cnt_q <= frame_cnt_q + 5'd1;
    end
  end

  // Stage B next state. Exhausted groups keep shifting zeros (index-0 colour);
  // an early char_load simply replaces the shifter contents.
  always_comb begin
    cfg_b_d  = cfg_b_q;
    attr_b_d = attr_b_q;
    shift_d  = shift_q;
    idx_d    = idx_q;
    if (load) begin
      cfg_b_d  = grp_a_q.cfg;
      attr_b_d = grp_a_q.byte1;
      shift_d  = (grp_a_q.cfg.mode == ModeText) ? {grp_a_q.font, 8'h00}
                                                : {grp_a_q.byte0, grp_a_q.byte1};
      idx_d    = '0;
    end else if (vid.pix_ce) begin
      shift_d = (cfg_b_q.mode == Mode320) ? (shift_q << 2) : (shift_q << 1);
      if (idx_q != '1) idx_d = idx_q + IdxW'(1);
    end
  end

  assign in_group = (idx_d < group_len(cfg_b_d.mode));

  // Colour is resolved from next-state values so video shows the pixel being entered.
  cga_palette_mux u_palette_mux (
    .cfg      (cfg_b_d),
    .attr     (attr_b_d),
    .pix      (shift_d[15:14]),
    .in_group (in_group),
    .colour   (colour_d)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cfg_b_q  <= cfg_reset();
      attr_b_q <= '0;
      shift_q  <= '0;
      idx_q    <= '0;
      video_q  <= '0;
    end else begin
      cfg_b_q  <= cfg_b_d;
      attr_b_q <= attr_b_d;
      shift_q  <= shift_d;
      idx_q    <= idx_d;
      if (vid.pix_ce) video_q <= colour_d;
    end
  end

  assign vid.video       = video_q;
  assign vid.hsync_out   = cfg_b_q.hsync;
  assign vid.vsync_l_out = cfg_b_q.vsync_l;

endmodule
